// File: rtl/game_flow_pkg.sv
// Shared encodings for the Breakout game-flow controller: screen codes seen by
// the VGA renderer and the lives field width.
package game_flow_pkg;

  localparam int unsigned SCR_W   = 3;
  localparam int unsigned LIVES_W = 3;

  localparam logic [SCR_W-1:0] SCR_START    = 3'd0;
  localparam logic [SCR_W-1:0] SCR_SELECT   = 3'd1;
  localparam logic [SCR_W-1:0] SCR_PLAY     = 3'd2;
  localparam logic [SCR_W-1:0] SCR_PAUSE    = 3'd3;
  localparam logic [SCR_W-1:0] SCR_CLEAR    = 3'd4;
  localparam logic [SCR_W-1:0] SCR_GAMEOVER = 3'd5;
  localparam logic [SCR_W-1:0] SCR_VICTORY  = 3'd6;

  // State encoding equals the screen code, so the state register drives `screen` directly.
  typedef enum logic [SCR_W-1:0] {
    StStart    = SCR_START,
    StSelect   = SCR_SELECT,
    StPlay     = SCR_PLAY,
    StPause    = SCR_PAUSE,
    StClear    = SCR_CLEAR,
    StGameOver = SCR_GAMEOVER,
    StVictory  = SCR_VICTORY
  } screen_e;

endpackage

// File: rtl/game_flow_fsm_if.sv
// Bundle between board inputs / ball engine (master) and the game-flow controller (slave).
interface game_flow_fsm_if #(
  parameter int unsigned NUM_LEVELS = 8
);
  import game_flow_pkg::*;

  localparam int unsigned LVL_W = $clog2(NUM_LEVELS + 1);

  logic                  start_btn;
  logic                  pause_btn;
  logic [LVL_W-1:0]      level_req;
  logic                  win;
  logic                  lose;
  logic [SCR_W-1:0]      screen;
  logic [LVL_W-1:0]      level;
  logic [LIVES_W-1:0]    lives;
  logic [NUM_LEVELS-1:0] unlocked;
  logic                  level_start;

  modport master (
    output start_btn, pause_btn, level_req, win, lose,
    input  screen, level, lives, unlocked, level_start
  );

  modport slave (
    input  start_btn, pause_btn, level_req, win, lose,
    output screen, level, lives, unlocked, level_start
  );

endinterface

// File: rtl/rise_detect.sv
// Single-bit rising-edge detector. The history flop resets high so a level held
// through reset never yields a spurious edge.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise
);

  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= sig;
    end
  end

  assign rise = sig & ~prev_q;

endmodule

// File: rtl/game_flow_fsm.sv
// Breakout game-flow controller: screen sequencing, current level, lives and the
// level unlock mask, all registered for the VGA renderer and ball engine.
module game_flow_fsm
  import game_flow_pkg::*;
#(
  parameter int unsigned NUM_LEVELS   = 8,
  parameter int unsigned LIVES        = 3,
  parameter int unsigned CLEAR_CYCLES = 50_000_000
) (
  input logic             clk,
  input logic             rst_n,
  game_flow_fsm_if.slave  bus
);

  localparam int unsigned LVL_W = $clog2(NUM_LEVELS + 1);
  localparam int unsigned TMR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

  localparam logic [LVL_W-1:0]      MaxLevel  = LVL_W'(NUM_LEVELS);
  localparam logic [LIVES_W-1:0]    FullLives = LIVES_W'(LIVES);
  localparam logic [TMR_W-1:0]      ClearLoad = TMR_W'(CLEAR_CYCLES - 1);
  localparam logic [NUM_LEVELS-1:0] UnlockRst = NUM_LEVELS'(1);

  logic start_r, pause_r, win_r, lose_r;

  rise_detect u_start_rise (.clk(clk), .rst_n(rst_n), .sig(bus.start_btn), .rise(start_r));
  rise_detect u_pause_rise (.clk(clk), .rst_n(rst_n), .sig(bus.pause_btn), .rise(pause_r));
  rise_detect u_win_rise   (.clk(clk), .rst_n(rst_n), .sig(bus.win),       .rise(win_r));
  rise_detect u_lose_rise  (.clk(clk), .rst_n(rst_n), .sig(bus.lose),      .rise(lose_r));

  screen_e               state_q;
  logic [LVL_W-1:0]      level_q;
  logic [LIVES_W-1:0]    lives_q;
  logic [NUM_LEVELS-1:0] unlocked_q;
  logic                  level_start_q;
  logic [TMR_W-1:0]      timer_q;

  logic                  req_ok;
  logic [NUM_LEVELS-1:0] next_unlock;

  // A request is honoured only for an in-range level whose unlock bit is set.
  always_comb begin
    req_ok = (bus.level_req != '0) && (bus.level_req <= MaxLevel) &&
             |(unlocked_q & (UnlockRst << (bus.level_req - LVL_W'(1))));
    // Bit `level_q` is the mask position of level level_q+1.
    next_unlock = unlocked_q | (UnlockRst << level_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StStart;
      level_q       <= '0;
      lives_q       <= FullLives;
      unlocked_q    <= UnlockRst;
      level_start_q <= 1'b0;
      timer_q       <= '0;
    end else begin
      level_start_q <= 1'b0;
      case (state_q)
        StStart: begin
          if (start_r) state_q <= StSelect;
        end
        StSelect: begin
          if (req_ok) begin
            state_q       <= StPlay;
            level_q       <= bus.level_req;
            lives_q       <= FullLives;
            level_start_q <= 1'b1;
          end
        end
        StPlay: begin
          if (win_r) begin
            if (level_q < MaxLevel) begin
              unlocked_q <= next_unlock;
              timer_q    <= ClearLoad;
              state_q    <= StClear;
            end else begin
              state_q <= StVictory;
            end
          end else if (lose_r) begin
            if (lives_q > LIVES_W'(1)) begin
              lives_q       <= lives_q - LIVES_W'(1);
              level_start_q <= 1'b1;
            end else begin
              lives_q <= '0;
              state_q <= StGameOver;
            end
          end else if (pause_r) begin
            state_q <= StPause;
          end
        end
        StPause: begin
          if (pause_r) begin
            state_q <= StPlay;
          end else if (start_r) begin
            state_q <= StSelect;
            level_q <= '0;
          end
        end
        StClear: begin
          if (start_r || (timer_q == '0)) begin
            state_q <= StSelect;
            level_q <= '0;
          end else begin
            timer_q <= timer_q - TMR_W'(1);
          end
        end
        StGameOver: begin
          if (start_r) begin
            state_q <= StSelect;
            lives_q <= FullLives;
            level_q <= '0;
          end
        end
        StVictory: begin
          if (start_r) begin
            state_q <= StStart;
            level_q <= '0;
          end
        end
        default: state_q <= StStart;
      endcase
    end
  end

  assign bus.screen      = state_q;
  assign bus.level       = level_q;
  assign bus.lives       = lives_q;
  assign bus.unlocked    = unlocked_q;
  assign bus.level_start = level_start_q;

endmodule

// File: tb/tb_game_flow_fsm.sv
// Scoreboard bench for game_flow_fsm: a behavioural model queues the expected
// outputs per clock, a monitor compares them against the DUT.
module tb_game_flow_fsm;

  localparam int NL = 8;
  localparam int LV = 3;
  localparam int CC = 4;

  typedef struct {
    int scr;
    int lvl;
    int lives;
    int unl;
    bit ls;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  game_flow_fsm_if #(.NUM_LEVELS(NL)) bus ();

  game_flow_fsm #(
    .NUM_LEVELS  (NL),
    .LIVES       (LV),
    .CLEAR_CYCLES(CC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  // Reference model state
  int m_scr, m_lvl, m_lives, m_tmr;
  bit m_unl[NL];
  bit m_ls;
  bit pv_s, pv_p, pv_w, pv_l;
  bit cur_s, cur_p, cur_w, cur_l;
  int cur_req;

  task automatic dchk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int unl_word();
    int w = 0;
    for (int i = 0; i < NL; i++) if (m_unl[i]) w += (1 << i);
    return w;
  endfunction

  function automatic void model_reset();
    m_scr = 0; m_lvl = 0; m_lives = LV; m_tmr = 0; m_ls = 0;
    for (int i = 0; i < NL; i++) m_unl[i] = (i == 0);
    pv_s = 1; pv_p = 1; pv_w = 1; pv_l = 1;
  endfunction

  // One clock of game rules, written from the screen-flow description.
  function automatic void model_step();
    bit es = cur_s && !pv_s;
    bit ep = cur_p && !pv_p;
    bit ew = cur_w && !pv_w;
    bit el = cur_l && !pv_l;
    pv_s = cur_s; pv_p = cur_p; pv_w = cur_w; pv_l = cur_l;
    m_ls = 0;
    case (m_scr)
      0: if (es) m_scr = 1;
      1: if (cur_req >= 1 && cur_req <= NL && m_unl[cur_req-1]) begin
           m_scr = 2; m_lvl = cur_req; m_lives = LV; m_ls = 1;
         end
      2: if (ew) begin
           if (m_lvl < NL) begin m_unl[m_lvl] = 1; m_scr = 4; m_tmr = CC - 1; end
           else m_scr = 6;
         end else if (el) begin
           if (m_lives > 1) begin m_lives--; m_ls = 1; end
           else begin m_lives = 0; m_scr = 5; end
         end else if (ep) m_scr = 3;
      3: if (ep) m_scr = 2;
         else if (es) begin m_scr = 1; m_lvl = 0; end
      4: if (es || m_tmr == 0) begin m_scr = 1; m_lvl = 0; end
         else m_tmr--;
      5: if (es) begin m_scr = 1; m_lives = LV; m_lvl = 0; end
      6: if (es) begin m_scr = 0; m_lvl = 0; end
      default: m_scr = 0;
    endcase
  endfunction

  function automatic void push_exp();
    exp_t e;
    e.scr = m_scr; e.lvl = m_lvl; e.lives = m_lives; e.unl = unl_word(); e.ls = m_ls;
    sb.push_back(e);
  endfunction

  task automatic drive(input bit s, input bit p, input int req, input bit w, input bit l);
    cur_s = s; cur_p = p; cur_w = w; cur_l = l; cur_req = req & 15;
    bus.start_btn = s;
    bus.pause_btn = p;
    bus.level_req = 4'(req);
    bus.win       = w;
    bus.lose      = l;
  endtask

  task automatic step(input bit s, input bit p, input int req, input bit w, input bit l);
    @(negedge clk);
    drive(s, p, req, w, l);
    model_step();
    push_exp();
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0);
  endtask

  task automatic settle();
    @(posedge clk);
    #3;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    model_step();
    push_exp();
  endtask

  task automatic check_reset_vals(input string tag);
    dchk({tag, " screen"}, int'(bus.screen), 0);
    dchk({tag, " unlocked"}, int'(bus.unlocked), 1);
    dchk({tag, " level"}, int'(bus.level), 0);
    dchk({tag, " lives"}, int'(bus.lives), LV);
    dchk({tag, " level_start"}, int'(bus.level_start), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_vals("async reset");
    repeat (2) @(posedge clk);
    release_reset();
  endtask

  // Monitor: every clock that has a queued expectation is compared.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        dchk("sb screen", int'(bus.screen), e.scr);
        dchk("sb level", int'(bus.level), e.lvl);
        dchk("sb lives", int'(bus.lives), e.lives);
        dchk("sb unlocked", int'(bus.unlocked), e.unl);
        dchk("sb level_start", int'(bus.level_start), int'(e.ls));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    drive(1, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    release_reset();

    step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0); settle();
    dchk("start held through reset", int'(bus.screen), 0);
    idle(); step(1, 0, 0, 0, 0); settle();
    dchk("start press to select", int'(bus.screen), 1);
    dchk("initial unlock mask", int'(bus.unlocked), 8'h01);
    step(0, 0, 3, 0, 0); step(0, 0, 3, 0, 0); settle();
    dchk("locked level stays", int'(bus.screen), 1);
    dchk("locked level no pulse", int'(bus.level_start), 0);
    step(0, 0, 1, 0, 0); settle();
    dchk("enter play", int'(bus.screen), 2);
    dchk("play level", int'(bus.level), 1);
    dchk("entry pulse", int'(bus.level_start), 1);
    idle(); settle();
    dchk("pulse one cycle", int'(bus.level_start), 0);

    step(0, 0, 0, 1, 0); settle();
    dchk("win to clear", int'(bus.screen), 4);
    dchk("unlock level 2", int'(bus.unlocked), 8'h03);
    repeat (3) idle();
    settle();
    dchk("banner still shown", int'(bus.screen), 4);
    idle(); settle();
    dchk("banner timeout", int'(bus.screen), 1);
    dchk("banner level cleared", int'(bus.level), 0);

    step(0, 0, 1, 0, 0); step(0, 0, 1, 1, 0); settle();
    dchk("second clear", int'(bus.screen), 4);
    step(1, 0, 0, 0, 0); settle();
    dchk("start skips banner", int'(bus.screen), 1);
    idle();

    step(0, 0, 2, 0, 0); settle();
    dchk("play level 2", int'(bus.level), 2);
    step(0, 0, 0, 0, 1); settle();
    dchk("lose to 2 lives", int'(bus.lives), 2);
    dchk("respawn pulse", int'(bus.level_start), 1);
    idle();
    step(0, 0, 0, 0, 1); idle();
    step(0, 0, 0, 0, 1); settle();
    dchk("game over", int'(bus.screen), 5);
    dchk("game over lives", int'(bus.lives), 0);
    idle(); step(1, 0, 0, 0, 0); settle();
    dchk("gameover restore lives", int'(bus.lives), LV);
    idle();

    step(0, 0, 1, 0, 0); step(0, 0, 0, 1, 1); settle();
    dchk("win beats lose", int'(bus.screen), 4);
    dchk("win keeps lives", int'(bus.lives), LV);
    step(1, 0, 0, 0, 0); idle();
    step(0, 0, 2, 0, 0); step(0, 1, 0, 0, 0); settle();
    dchk("pause", int'(bus.screen), 3);
    idle(); step(0, 0, 0, 1, 0); settle();
    dchk("win ignored in pause", int'(bus.screen), 3);
    idle(); step(1, 1, 0, 0, 0); settle();
    dchk("pause beats quit", int'(bus.screen), 2);
    dchk("resume no pulse", int'(bus.level_start), 0);
    idle();

    step(0, 0, 0, 1, 0);
    repeat (5) idle();
    for (int lv = 3; lv <= NL; lv++) begin
      step(0, 0, lv, 0, 0);
      step(0, 0, 0, 1, 0);
      repeat (5) idle();
    end
    settle();
    dchk("victory", int'(bus.screen), 6);
    dchk("all unlocked", int'(bus.unlocked), 8'hff);
    step(1, 0, 0, 0, 0); settle();
    dchk("victory to start", int'(bus.screen), 0);
    idle();

    step(1, 0, 0, 0, 0); idle();
    step(0, 0, 5, 0, 0); step(0, 0, 0, 1, 0); idle();
    do_reset();

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        bit s = ($urandom_range(0, 2) == 0);
        bit p = ($urandom_range(0, 4) == 0);
        bit w = ($urandom_range(0, 6) == 0);
        bit l = ($urandom_range(0, 5) == 0);
        int r = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 4);
        step(s, p, r, w, l);
      end
    end

    repeat (3) @(posedge clk);
    #2;
    dchk("scoreboard drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/game_flow_fsm.md
Name: game_flow_fsm

Overview:
- Parametrised top-level game-flow controller for Breakout.
- Sequences start menu, level select, play, pause, level-cleared banner, game over and final victory screens.
- Tracks the current level, remaining lives and a per-level unlock mask.
- Sits between the debounced button/switch inputs plus the ball/brick engine (win/lose) and the VGA screen renderer, which consumes `screen`, `level`, `lives` and `unlocked`.

Parameters:
- NUM_LEVELS, 8, number of playable levels (1..15).
- LIVES, 3, lives granted at each level start (1..7).
- CLEAR_CYCLES, 50_000_000, clock cycles the level-cleared banner is shown (>=1).
- LVL_W (localparam), $clog2(NUM_LEVELS+1), width of level fields.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start_btn  in  1  debounced start/confirm button, level-sensitive.
- pause_btn  in  1  debounced pause button, level-sensitive.
- level_req  in  LVL_W  level chosen on switches; 0 = none.
- win  in  1  engine: all bricks cleared.
- lose  in  1  engine: ball lost.
- screen  out  3  current screen code (package encoding).
- level  out  LVL_W  active level; 0 when none.
- lives  out  3  remaining lives.
- unlocked  out  NUM_LEVELS  bit i = level i+1 selectable.
- level_start  out  1  one-cycle pulse: engine must (re)load level/ball.

Behaviour:
- Inputs and edge detection:
  - start_btn, pause_btn, win and lose each pass through a rising-edge detector.
  - The detector previous-value flop resets to 1, so an input held high through reset produces no edge.
  - All decisions below use the edges: start_r, pause_r, win_r, lose_r.
- Outputs: all registered; updates are visible the cycle after the triggering edge.
- Reset values (asynchronous): screen=START, level=0, lives=LIVES, unlocked=1 (level 1 only), level_start=0, banner timer=0.
- Screen encoding: START=0, SELECT=1, PLAY=2, PAUSE=3, CLEAR=4, GAMEOVER=5, VICTORY=6. Codes 7 or any illegal value -> START next cycle.
- START: start_r -> SELECT.
- SELECT:
  - If level_req is in 1..NUM_LEVELS and unlocked[level_req-1]=1: go to PLAY, level<=level_req, lives<=LIVES, pulse level_start.
  - level_req of 0, out of range, or locked: stay in SELECT, no pulse.
- PLAY:
  - Priority: win_r > lose_r > pause_r.
  - win_r: if level<NUM_LEVELS, set unlocked[level] and go to CLEAR with timer<=CLEAR_CYCLES-1. If level==NUM_LEVELS, go to VICTORY.
  - lose_r with lives>1: lives-1, stay in PLAY, pulse level_start (respawn).
  - lose_r with lives==1: lives<=0, go to GAMEOVER.
  - pause_r: go to PAUSE.
- PAUSE:
  - win and lose are ignored; their edges are not queued.
  - pause_r -> PLAY, with no level_start.
  - start_r (quit) -> SELECT, level<=0.
  - pause_r and start_r in the same cycle: pause_r wins.
- CLEAR:
  - Timer decrements each cycle; at 0 go to SELECT with level<=0.
  - start_r skips the banner immediately.
- GAMEOVER: start_r -> SELECT, lives<=LIVES, level<=0.
- VICTORY: start_r -> START, level<=0.
- Unlock mask:
  - Bits only ever set; never cleared except by reset.
  - Unlocking an already-unlocked level is a no-op.
- level_start: high exactly one cycle per event. Never high in any screen other than PLAY entry or respawn.
- Reset mid-operation (any state, any timer value): everything returns to the reset values, including the unlock mask.
- Synthesis: NUM_LEVELS=1 must elaborate. In that case win in PLAY goes straight to VICTORY.

Decomposition:
- Package game_flow_pkg holds:
  - screen code localparams (SCR_START..SCR_VICTORY, width 3);
  - LIVES_W=3.
- One sub-module, rise_detect: one bit, clk/rst_n, reset-high previous flop, output in & ~prev. Instantiate 4x.
- FSM, counters and unlock mask live in game_flow_fsm.

Test Plan (NUM_LEVELS=8, LIVES=3, CLEAR_CYCLES=4):
- Reset with start_btn held high, then release and press -> no transition while held; one press gives START->SELECT; unlocked=8'h01.
- In SELECT set level_req=3 (locked) -> stays SELECT, no pulse. Set level_req=1 -> PLAY, level=1, lives=3, one-cycle level_start.
- In PLAY level 1, assert win -> CLEAR, unlocked=8'h03. After 4 cycles -> SELECT, level=0. Repeat, pressing start on the first CLEAR cycle -> SELECT immediately.
- In PLAY, three lose pulses -> lives 2, 1 with a level_start pulse each, then GAMEOVER with lives=0. Press start -> SELECT, lives=3.
- In PLAY assert win and lose in the same cycle -> CLEAR, lives unchanged. In PAUSE assert win -> ignored; press pause and start together -> PLAY.
- Unlock all levels, win level 8 -> VICTORY; start -> START. Assert rst_n=0 mid-CLEAR -> screen=0, unlocked=8'h01 asynchronously.
